// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard/redirect controller
package pipe_ctrl_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BUSY_HOLD = 2'd1,
        REDIRECT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - load-use comparator between ID sources and EX destination
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_ren_i,
    input  logic                  id_rs2_ren_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_rd_wen_i,
    input  logic                  ex_is_load_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);

    // x0 is hardwired zero, so a load targeting it can never be a real dependency
    assign load_use_o = ex_is_load_i && ex_rd_wen_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hold/flush/redirect controller; PIPE_CTRL_PERF_EN enables stall/flush counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BUSY_MAX = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_ren,
    input  logic                  id_rs2_ren,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_wen,
    input  logic                  ex_is_load,
    input  logic                  ex_jump_en,
    input  logic [31:0]           ex_jump_addr,
    input  logic                  ex_busy,
    input  logic                  perf_clr,
    output logic                  hold_pc,
    output logic                  hold_if_id,
    output logic                  hold_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  pc_load_en,
    output logic [31:0]           pc_load_addr,
    output logic                  busy_timeout,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
);

    localparam logic [15:0] BUSY_MAX_C = 16'(BUSY_MAX);

    state_e      state_q, state_d;
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        busy_timeout_q;
    logic        load_use;

    pipe_ctrl_hazard u_hazard (
        .id_rs1_addr_i (id_rs1_addr),
        .id_rs2_addr_i (id_rs2_addr),
        .id_rs1_ren_i  (id_rs1_ren),
        .id_rs2_ren_i  (id_rs2_ren),
        .ex_rd_addr_i  (ex_rd_addr),
        .ex_rd_wen_i   (ex_rd_wen),
        .ex_is_load_i  (ex_is_load),
        .load_use_o    (load_use)
    );

    // Controls are gated by rst so they drop the instant reset asserts, even with ex_busy high
    always_comb begin
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_load_en  = 1'b0;
        state_d     = RUN;
        if (rst) begin
            state_d = RUN;
        end else if (ex_busy) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            state_d    = BUSY_HOLD;
        end else if (ex_jump_en && state_q != REDIRECT) begin
            pc_load_en  = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = REDIRECT;
        end else if (load_use && state_q != REDIRECT) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = RUN;
        end
    end

    assign pc_load_addr = rst ? 32'h0 : ex_jump_addr;
    assign busy_cnt_d   = !ex_busy ? 16'h0 :
                          (busy_cnt_q == BUSY_MAX_C) ? busy_cnt_q : busy_cnt_q + 16'h1;
    assign busy_timeout = busy_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            busy_cnt_q     <= 16'h0;
            busy_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            if (ex_busy && busy_cnt_d == BUSY_MAX_C) begin
                busy_timeout_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 32'h0;
        end else if (perf_clr) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 32'h0;
        end else begin
            if (hold_pc) begin
                stall_cycles_q <= stall_cycles_q + 32'h1;
            end
            if (flush_if_id || flush_id_ex) begin
                flush_count_q <= flush_count_q + 32'h1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic perf_clr_unused;

    assign perf_clr_unused = perf_clr;
    assign stall_cycles    = 32'h0;
    assign flush_count     = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int TB_BUSY_MAX = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_ren, id_rs2_ren, ex_rd_wen, ex_is_load;
    logic        ex_jump_en, ex_busy, perf_clr;
    logic [31:0] ex_jump_addr;
    logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_load_en;
    logic [31:0] pc_load_addr;
    logic        busy_timeout;
    logic [31:0] stall_cycles, flush_count;

    pipe_ctrl #(.BUSY_MAX(TB_BUSY_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_ren   (id_rs1_ren),
        .id_rs2_ren   (id_rs2_ren),
        .ex_rd_addr   (ex_rd_addr),
        .ex_rd_wen    (ex_rd_wen),
        .ex_is_load   (ex_is_load),
        .ex_jump_en   (ex_jump_en),
        .ex_jump_addr (ex_jump_addr),
        .ex_busy      (ex_busy),
        .perf_clr     (perf_clr),
        .hold_pc      (hold_pc),
        .hold_if_id   (hold_if_id),
        .hold_id_ex   (hold_id_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .pc_load_en   (pc_load_en),
        .pc_load_addr (pc_load_addr),
        .busy_timeout (busy_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] dut_ctl = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_load_en};

    int checks = 0;
    int passed = 0;

    // Model history: did the previous cycle redirect, how long has busy lasted
    bit          m_prev_redirect;
    int          m_busy_run;
    bit          m_timeout;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    task automatic model_reset();
        m_prev_redirect = 0;
        m_busy_run      = 0;
        m_timeout       = 0;
        m_stall         = 32'h0;
        m_flush         = 32'h0;
    endtask

    // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_load_en}
    function automatic logic [5:0] model_ctl();
        bit dep;
        dep = ex_is_load && ex_rd_wen && (ex_rd_addr != 5'd0) &&
              ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
        if (ex_busy)                          return 6'b111000;
        if (ex_jump_en && !m_prev_redirect)   return 6'b000111;
        if (dep && !m_prev_redirect)          return 6'b110010;
        return 6'b000000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        id_rs1_addr  = 5'd0; id_rs2_addr = 5'd0; id_rs1_ren = 1'b0; id_rs2_ren = 1'b0;
        ex_rd_addr   = 5'd0; ex_rd_wen   = 1'b0; ex_is_load = 1'b0;
        ex_jump_en   = 1'b0; ex_jump_addr = 32'h0; ex_busy = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
        ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd_addr = rd;
        id_rs1_addr = rs1; id_rs1_ren = 1'b1;
    endtask

    // Called just after a negedge with inputs already driven; checks, clocks, advances the model
    task automatic tick(input string tag);
        logic [5:0] e;
        #1;
        e = model_ctl();
        check({tag, "/ctl"}, 32'(dut_ctl), 32'(e));
        if (e[0]) check({tag, "/addr"}, pc_load_addr, ex_jump_addr);
        check({tag, "/timeout"}, 32'(busy_timeout), 32'(m_timeout));
        check({tag, "/stall"}, stall_cycles, m_stall);
        check({tag, "/flush"}, flush_count, m_flush);
        @(posedge clk);
        m_prev_redirect = e[0];
        if (ex_busy) m_busy_run = (m_busy_run + 1 > TB_BUSY_MAX) ? TB_BUSY_MAX : m_busy_run + 1;
        else         m_busy_run = 0;
        if (m_busy_run >= TB_BUSY_MAX) m_timeout = 1;
`ifdef PIPE_CTRL_PERF_EN
        if (perf_clr) begin
            m_stall = 32'h0;
            m_flush = 32'h0;
        end else begin
            if (e[5]) m_stall = m_stall + 32'h1;
            if (e[2] || e[1]) m_flush = m_flush + 32'h1;
        end
`endif
        @(negedge clk);
    endtask

    // Reset asserted between edges: every control must drop without waiting for a clock
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "/ctl"}, 32'(dut_ctl), 32'h0);
        check({tag, "/timeout"}, 32'(busy_timeout), 32'h0);
        check({tag, "/stall"}, stall_cycles, 32'h0);
        check({tag, "/flush"}, flush_count, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        check("reset/ctl", 32'(dut_ctl), 32'h0);
        check("reset/addr", pc_load_addr, 32'h0);
        check("reset/timeout", 32'(busy_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        set_load_use(5'd5, 5'd5);
        #1 check("lu_x5/explicit", 32'(dut_ctl), 32'b110010);
        tick("lu_x5");
        idle();
        tick("lu_after");

        set_load_use(5'd0, 5'd0);
        tick("lu_x0");
        idle();

        ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100;
        #1 check("jump/addr_explicit", pc_load_addr, 32'h0000_0100);
        tick("jump");
        tick("jump_masked");
        idle();
        tick("jump_after");

        ex_busy = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0200;
        set_load_use(5'd7, 5'd7);
        for (int i = 0; i < 3; i++) tick("busy3");
        ex_busy = 1'b0;
        #1 check("busy_drop/explicit", 32'(dut_ctl), 32'b000111);
        tick("busy_drop");
        idle();
        tick("busy_drop_after");

        for (int i = 0; i < 400; i++) begin
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            id_rs1_ren   = 1'($urandom);
            id_rs2_ren   = 1'($urandom);
            ex_rd_addr   = 5'($urandom_range(0, 3));
            ex_rd_wen    = 1'($urandom);
            ex_is_load   = 1'($urandom);
            ex_jump_en   = ($urandom_range(0, 3) == 0);
            ex_jump_addr = $urandom;
            ex_busy      = ex_busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 7) == 0);
            perf_clr     = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        async_reset("rst_rand");

        ex_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick("tmo_busy");
            if (i == 2) check("tmo/not_yet", 32'(busy_timeout), 32'h0);
        end
        check("tmo/set", 32'(busy_timeout), 32'h1);
        ex_busy = 1'b0;
        tick("tmo_idle");
        tick("tmo_idle");
        check("tmo/sticky", 32'(busy_timeout), 32'h1);
        ex_busy = 1'b1;
        tick("tmo_busy_again");
        async_reset("rst_mid_busy");
        tick("post_rst");

`ifdef PIPE_CTRL_PERF_EN
        set_load_use(5'd9, 5'd9);
        tick("perf_lu");
        idle();
        ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0400;
        tick("perf_jump");
        idle();
        tick("perf_idle");
        check("perf/stall_explicit", stall_cycles, 32'd1);
        check("perf/flush_explicit", flush_count, 32'd2);
        perf_clr = 1'b1;
        set_load_use(5'd9, 5'd9);
        tick("perf_clr");
        idle();
        #1;
        check("perf/stall_cleared", stall_cycles, 32'd0);
        check("perf/flush_cleared", flush_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
